// File: rtl/mult_pkg.sv
// Shared constants and helpers for the pipelined Baugh-Wooley multiplier.
package mult_pkg;

    // Product width for an n-bit by n-bit multiply; the full product is never truncated.
    function automatic int pw_of(input int n);
        return 2 * n;
    endfunction

    // Correction row added during reduction. It balances the complemented sign-row
    // partial products in two's complement mode: 2^n + 2^(2n-1). It is zero for unsigned.
    // The result is returned 64 bits wide so that n up to 32 fits, and the caller
    // truncates it to its product width.
    function automatic logic [63:0] bw_const(input int n, input logic is_signed);
        if (!is_signed) begin
            return 64'd0;
        end
        return (64'd1 << n) | (64'd1 << (2 * n - 1));
    endfunction

endpackage

// File: rtl/csa_row.sv
// Bitwise 3:2 compressor: reduces three W-bit rows to a sum row and a carry row.
// The carry row is shifted left by one, and its top carry is dropped (mod 2^W).
module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = x ^ y ^ z;
    assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/mult_bw_pipe.sv
// Three-stage pipelined NxN multiplier, Baugh-Wooley style, with a signed/unsigned mode
// selected per transaction.
// Stage 1 registers the partial products. Stage 2 registers the carry-save sum and carry.
// Stage 3 registers the final carry-propagate sum.
// A single global stall (adv) freezes every stage while a result waits at the output.
module mult_bw_pipe
    import mult_pkg::*;
#(
    parameter  int N  = 8,
    localparam int PW = pw_of(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_p
);

    logic                  adv;
    logic                  v1, v2, v3;
    logic [N-1:0][N-1:0]   pp;
    logic [N-1:0][N-1:0]   pp_q;
    logic                  sgn_q;
    logic [PW-1:0]         rows [N+1];
    logic [PW-1:0]         red_sum;
    logic [PW-1:0]         red_carry;
    logic [PW-1:0]         sum_q;
    logic [PW-1:0]         carry_q;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    // Partial product rows. In signed mode, the sign-row and sign-column terms are
    // complemented, except for the MSB*MSB term, which keeps positive weight.
    always_comb begin
        pp = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                pp[j][i] = in_a[i] & in_b[j];
                if (in_signed && ((i == N - 1) != (j == N - 1))) begin
                    pp[j][i] = ~pp[j][i];
                end
            end
        end
    end

    // Align the registered partial products to their column weights, and append the
    // correction row.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            rows[j] = {{N{1'b0}}, pp_q[j]} << j;
        end
        rows[N] = PW'(bw_const(N, sgn_q));
    end

    // Carry-save reduction of N+1 rows. The first compressor takes three rows, and each
    // later one folds one more row into the running sum/carry pair. This takes N-1
    // compressors in total.
    for (genvar k = 0; k < N - 1; k++) begin : g_red
        logic [PW-1:0] x_in, y_in, s, c;
        if (k == 0) begin : g_first
            assign x_in = rows[0];
            assign y_in = rows[1];
        end else begin : g_next
            assign x_in = g_red[k-1].s;
            assign y_in = g_red[k-1].c;
        end
        csa_row #(.W(PW)) u_csa (
            .x     (x_in),
            .y     (y_in),
            .z     (rows[k+2]),
            .sum   (s),
            .carry (c)
        );
    end

    assign red_sum   = g_red[N-2].s;
    assign red_carry = g_red[N-2].c;

    // Pipeline registers and the valid chain. All of them advance together on adv.
    // Bubbles travel through the pipeline like ordinary data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            pp_q    <= '0;
            sgn_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            out_p   <= '0;
        end else if (adv) begin
            v1      <= in_valid;
            v2      <= v1;
            v3      <= v2;
            pp_q    <= pp;
            sgn_q   <= in_signed;
            sum_q   <= red_sum;
            carry_q <= red_carry;
            out_p   <= sum_q + carry_q;
        end
    end

endmodule

// File: tb/tb_mult_bw_pipe.sv
// Directed and randomized-handshake bench for mult_bw_pipe at N=8.
module tb_mult_bw_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;

    int n_chk;
    int n_pass;

    mult_bw_pipe #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown(in_valid));
            if (in_valid === 1'b1) begin
                assert (!$isunknown({in_a, in_b, in_signed}));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // One isolated operation on an empty pipe with out_ready=1.
    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] exp);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        step();
        chk({tag, "_lat2"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_p"}, out_p, exp);
        step();
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    vec_t b2b [4];
    vec_t bp  [4];
    logic [15:0] q [$];
    logic [15:0] e;

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Isolated operations with hand-computed products.
        run_one("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_one("s_m128_127",  8'h80, 8'h7F, 1'b1, 16'hC080);
        run_one("u_255_255",   8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_one("s_m1_5",      8'hFF, 8'h05, 1'b1, 16'hFFFB);
        run_one("u_0_200",     8'h00, 8'hC8, 1'b0, 16'h0000);

        // Back-to-back operations with the mode alternating on every cycle.
        b2b[0] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        b2b[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        b2b[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        b2b[3] = '{8'h0F, 8'h10, 1'b0, 16'h00F0};
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                in_a = b2b[k].a; in_b = b2b[k].b; in_signed = b2b[k].s; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (k >= 2 && k <= 5) begin
                chk($sformatf("b2b_valid%0d", k - 2), out_valid, 1);
                chk($sformatf("b2b_p%0d", k - 2), out_p, b2b[k-2].p);
            end
            if (k == 6) chk("b2b_drained", out_valid, 0);
        end

        // Backpressure: fill the pipe, then stall for 5 cycles with a fourth op waiting.
        bp[0] = '{8'h03, 8'h05, 1'b0, 16'h000F};
        bp[1] = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
        bp[2] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        bp[3] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_a = bp[k].a; in_b = bp[k].b; in_signed = bp[k].s; in_valid = 1'b1;
            step();
        end
        in_a = bp[3].a; in_b = bp[3].b; in_signed = bp[3].s; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
            chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_hold_p%0d", k), out_p, bp[0].p);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("bp_rel_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_rel_p%0d", k), out_p, bp[k].p);
            step();
        end
        chk("bp_drained", out_valid, 0);

        // Reset with three operations in flight.
        for (int k = 0; k < 3; k++) begin
            in_a = b2b[k].a; in_b = b2b[k].b; in_signed = b2b[k].s; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_p", out_p, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_rst_idle%0d", k), out_valid, 0);
        end
        run_one("post_rst_op", 8'h06, 8'h07, 1'b0, 16'h002A);

        // Randomized operands, mode and handshake, checked against a scoreboard.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_signed = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_p", out_p, e);
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_signed));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_drain_p", out_p, e);
                end
            end
            step();
        end
        chk("rnd_left", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
